// File: rtl/swo_uart_rx_pkg.sv
// Shared definitions for the SWO NRZ receiver: FSM state encoding and divisor floor.
package swo_uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_e;

    localparam int unsigned MIN_DIV = 3;

endpackage

// File: rtl/swo_uart_rx_if.sv
// Byte output channel of the SWO receiver: one-deep valid/ready register toward capture.
interface swo_uart_rx_if;
    logic [7:0] O_data;
    logic       O_data_valid;
    logic       I_data_ready;

    modport master (output O_data, output O_data_valid, input I_data_ready);
    modport slave  (input O_data, input O_data_valid, output I_data_ready);
endinterface

// File: rtl/swo_uart_rx_sync.sv
// Multi-flop synchroniser for the raw SWO pin plus falling-edge detect on the synchronised line.
module swo_sync #(
    parameter int pSYNC_STAGES = 2
) (
    input  logic trace_clk,
    input  logic reset_n,
    input  logic i_swo,
    output logic o_s_swo,
    output logic o_fall
);
    logic [pSYNC_STAGES-1:0] r_sync;
    logic                    r_prev;

    // Preset high so that reset never looks like a start edge on an idle line.
    always_ff @(posedge trace_clk) begin
        if (!reset_n) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[pSYNC_STAGES-2:0], i_swo};
            r_prev <= r_sync[pSYNC_STAGES-1];
        end
    end

    assign o_s_swo = r_sync[pSYNC_STAGES-1];
    assign o_fall  = r_prev & ~r_sync[pSYNC_STAGES-1];
endmodule

// File: rtl/swo_uart_rx.sv
// 8N1 UART-mode SWO receiver: mid-bit sampling FSM feeding a one-deep output register.
module swo_uart_rx
    import swo_uart_rx_pkg::*;
#(
    parameter int pDIV_WIDTH   = 16,
    parameter int pSYNC_STAGES = 2
) (
    input  logic                  trace_clk,
    input  logic                  reset_n,
    input  logic                  swo,
    input  logic                  I_enable,
    input  logic [pDIV_WIDTH-1:0] I_baud_div,
    input  logic                  I_clear_errors,
    output logic                  O_framing_error,
    output logic                  O_overrun,
    output logic                  O_busy,
    swo_uart_rx_if.master         rx_if
);
    logic                  w_s_swo;
    logic                  w_fall;
    logic [pDIV_WIDTH-1:0] w_div;
    logic                  w_accept;
    logic                  w_overrun;

    rx_state_e             r_state;
    logic [pDIV_WIDTH-1:0] r_cnt;
    logic [pDIV_WIDTH-1:0] r_div;
    logic [2:0]            r_bit;
    logic [7:0]            r_shift;
    logic                  r_deliver;
    logic                  r_ferr;
    logic [7:0]            r_data;
    logic                  r_valid;
    logic                  r_ovr;

    swo_sync #(.pSYNC_STAGES(pSYNC_STAGES)) u_sync (
        .trace_clk (trace_clk),
        .reset_n   (reset_n),
        .i_swo     (swo),
        .o_s_swo   (w_s_swo),
        .o_fall    (w_fall)
    );

    assign w_div = (I_baud_div < pDIV_WIDTH'(MIN_DIV)) ? pDIV_WIDTH'(MIN_DIV) : I_baud_div;

    always_ff @(posedge trace_clk) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_div     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_deliver <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_deliver <= 1'b0;
            r_ferr    <= 1'b0;
            if (!I_enable) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_fall) begin
                            r_div   <= w_div;
                            r_cnt   <= w_div >> 1;
                            r_state <= ST_START;
                        end
                    end
                    ST_START: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else if (w_s_swo) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt   <= r_div;
                            r_bit   <= '0;
                            r_state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            r_shift <= {w_s_swo, r_shift[7:1]};
                            r_cnt   <= r_div;
                            if (r_bit == 3'd7) r_state <= ST_STOP;
                            else               r_bit   <= r_bit + 3'd1;
                        end
                    end
                    ST_STOP: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else if (w_s_swo) begin
                            r_deliver <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= ST_WAIT_IDLE;
                        end
                    end
                    // Hold off through a break so its release is not taken as a start edge.
                    ST_WAIT_IDLE: begin
                        if (w_s_swo) r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign w_accept  = r_valid & rx_if.I_data_ready;
    assign w_overrun = r_deliver & r_valid & ~rx_if.I_data_ready;

    always_ff @(posedge trace_clk) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (r_deliver && !w_overrun) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
            if (w_overrun)           r_ovr <= 1'b1;
            else if (I_clear_errors) r_ovr <= 1'b0;
        end
    end

    assign rx_if.O_data       = r_data;
    assign rx_if.O_data_valid = r_valid;
    assign O_framing_error    = r_ferr;
    assign O_overrun          = r_ovr;
    assign O_busy             = (r_state != ST_IDLE);
endmodule
